multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, memory port, IR, PC and register-file write strobes across FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives the 2-bit alu_op consumed by the existing ALU control decoder:
  - 00 = add
  - 01 = subtract/branch
  - 10 = R-type
  - 11 = I-type
- One instruction takes 3–5 cycles plus memory wait states.

Parameters:
- RESET_TRAP, 0, 1 = illegal opcode enters a sticky TRAP state; 0 = illegal opcode is treated as NOP (returns to FETCH).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the IR, valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register
- mem_write  out  1  store strobe
- ir_write  out  1  IR/old-PC load enable
- pc_write  out  1  unconditional PC update
- branch  out  1  conditional PC update (datapath ANDs with zero)
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- result_src  out  2  result select: 00 = ALU-out register, 01 = memory data, 10 = ALU result
- alu_op  out  2  to ALU control decoder
- illegal_instr  out  1  sticky flag, high in TRAP
- instret  out  32  retired-instruction count (0 when feature disabled)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Outputs are decoded from state (Moore), except ir_write and pc_write in FETCH, which equal mem_ready.
- Any field not listed for a state is 0.
- Reset:
  - rst_n low → state = FETCH asynchronously.
  - While rst_n is low: mem_req, mem_write, ir_write, pc_write, reg_write, branch are forced 0; illegal_instr = 0; instret = 0.
  - First FETCH request is made in the first cycle after release.
  - Reset asserted mid-instruction aborts immediately; no strobe completes.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_write=mem_ready.
  - Holds until mem_ready, then → DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target).
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode → TRAP if RESET_TRAP=1, else → FETCH.
- MEMADR: a=10, b=01, alu_op=00.
  - opcode[5]=0 → MEMREAD; opcode[5]=1 → MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00.
  - Holds until mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1, result_src=00.
  - mem_write stays high until mem_ready, then → FETCH.
- EXECR: a=10, b=00, alu_op=10 → ALUWB.
- EXECI: a=10, b=01, alu_op=11 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1 → FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB (writes PC+4 to rd).
- TRAP: all strobes 0, illegal_instr=1; exits only via reset.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Latency with zero wait states: R/I/JAL = 4 cycles, lw = 5, sw = 4, beq = 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTRET_EN.
- Defined:
  - instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - JAL counts once, via ALUWB.
  - Wraps 0xFFFFFFFF → 0.
  - Not incremented for NOP-treated illegal opcodes.
- Undefined: instret tied to 0; no counter flops.

Decomposition:
- Shared package mc_pkg holds:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - alu_op constants
  - mux-select constants for alu_src_a, alu_src_b, result_src
- Single module; no sub-module is natural. The next-state and output decode are both small case statements.

Test Plan:
- Reset low for 3 cycles, then release with mem_ready=1 → all strobes 0 during reset; FETCH has mem_req=1 and ir_write=pc_write=1 in the first cycle after release.
- add (opcode 0110011) with mem_ready=1 → FETCH, DECODE, EXECR (alu_op=10), ALUWB (reg_write=1), FETCH; 4 cycles total.
- lw with mem_ready low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with adr_src=1; MEMWB asserts result_src=01 and reg_write=1.
- sw with mem_ready delayed 1 cycle → mem_write high for exactly 2 cycles; reg_write never asserted.
- Opcode 1110011 with RESET_TRAP=1 → TRAP, illegal_instr=1, mem_req=0 held for 10 cycles; rst_n pulse clears it. With RESET_TRAP=0 → returns to FETCH, instret unchanged.
- With MULTICYCLE_CTRL_INSTRET_EN: 3 instructions (jal, beq, addi) → instret=3; preload near wrap so the count rolls over to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM:
// state encoding, opcode values, ALU/mux select codes and the per-state output decode.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // fetch marks the state whose IR/PC strobes follow mem_ready combinationally.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_MEMDATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXECUTE/MEM/WB).
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        branch,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_op,
    output logic        illegal_instr,
    output logic [31:0] instret
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = RESET_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
        end
    end

    // Strobes are gated by rst_n so nothing fires while reset is held,
    // yet the FETCH request is already present in the first cycle after release.
    assign mem_req       = ctrl_q.mem_req & rst_n;
    assign adr_src       = ctrl_q.adr_src;
    assign mem_write     = ctrl_q.mem_write & rst_n;
    assign ir_write      = ctrl_q.fetch & mem_ready & rst_n;
    assign pc_write      = (ctrl_q.pc_write | (ctrl_q.fetch & mem_ready)) & rst_n;
    assign branch        = ctrl_q.branch & rst_n;
    assign reg_write     = ctrl_q.reg_write & rst_n;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign result_src    = ctrl_q.result_src;
    assign alu_op        = ctrl_q.alu_op;
    assign illegal_instr = ctrl_q.illegal & rst_n;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    // JAL retires through ALUWB; NOP-treated illegal opcodes leave from DECODE and never count.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BEQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: one instance with illegal opcodes as NOP,
// one with the sticky trap, both driven by the same stimulus.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] SYS  = 7'b1110011;

    // {mem_req, adr_src, mem_write, ir_write, pc_write, branch, reg_write, a, b, result_src, alu_op, illegal}
    localparam logic [15:0] V_DECODE   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMADR   = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMREAD  = {7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMWB    = {7'b0000001, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMWRITE = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_EXECR    = {7'b0000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] V_EXECI    = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b11, 1'b0};
    localparam logic [15:0] V_ALUWB    = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_BEQ      = {7'b0000010, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [15:0] V_JAL      = {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] V_TRAP     = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    // mem_req, mem_write, ir_write, pc_write, branch, reg_write, illegal
    localparam logic [15:0] STROBE_MASK = 16'b1011_1110_0000_0001;

    function automatic logic [15:0] v_fetch(input logic mr);
        return {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        mem_ready = 1'b0;

    logic        mem_req0, adr_src0, mem_write0, ir_write0, pc_write0, branch0, reg_write0, illegal0;
    logic [1:0]  alu_src_a0, alu_src_b0, result_src0, alu_op0;
    logic [31:0] instret0;
    logic        mem_req1, adr_src1, mem_write1, ir_write1, pc_write1, branch1, reg_write1, illegal1;
    logic [1:0]  alu_src_a1, alu_src_b1, result_src1, alu_op1;
    logic [31:0] instret1;
    logic [15:0] obs0, obs1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt0 = '0;
    logic [31:0] cnt1 = '0;
    logic [6:0]  ops[6] = '{LW, SW, ADD, ADDI, BEQ, JAL};

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_TRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req0), .adr_src(adr_src0), .mem_write(mem_write0),
        .ir_write(ir_write0), .pc_write(pc_write0), .branch(branch0),
        .reg_write(reg_write0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .result_src(result_src0), .alu_op(alu_op0), .illegal_instr(illegal0),
        .instret(instret0)
    );

    multicycle_ctrl #(.RESET_TRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req1), .adr_src(adr_src1), .mem_write(mem_write1),
        .ir_write(ir_write1), .pc_write(pc_write1), .branch(branch1),
        .reg_write(reg_write1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .result_src(result_src1), .alu_op(alu_op1), .illegal_instr(illegal1),
        .instret(instret1)
    );

    assign obs0 = {mem_req0, adr_src0, mem_write0, ir_write0, pc_write0, branch0, reg_write0,
                   alu_src_a0, alu_src_b0, result_src0, alu_op0, illegal0};
    assign obs1 = {mem_req1, adr_src1, mem_write1, ir_write1, pc_write1, branch1, reg_write1,
                   alu_src_a1, alu_src_b1, result_src1, alu_op1, illegal1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive mem_ready, check both instances mid-cycle, advance past the edge.
    task automatic step(input logic mr, input logic [15:0] e0, input logic [15:0] e1, input string tag);
        mem_ready = mr;
        @(negedge clk);
        chk({tag, "_nop"}, {16'b0, obs0}, {16'b0, e0});
        chk({tag, "_trap"}, {16'b0, obs1}, {16'b0, e1});
        chk({tag, "_instret_nop"}, instret0, cnt0);
        chk({tag, "_instret_trap"}, instret1, cnt1);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one();
        if (INSTRET_ON) begin
            cnt0 = cnt0 + 32'd1;
            cnt1 = cnt1 + 32'd1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        cnt0 = '0;
        cnt1 = '0;
        for (int i = 0; i < cycles; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("reset_strobes_nop", {16'b0, obs0 & STROBE_MASK}, 32'd0);
            chk("reset_strobes_trap", {16'b0, obs1 & STROBE_MASK}, 32'd0);
            chk("reset_instret_nop", instret0, 32'd0);
            chk("reset_instret_trap", instret1, 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Expected cycle sequence of one legal instruction, built from the state table.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        logic [15:0] v;
        opcode = op;
        for (int i = 0; i < fw; i++) step(1'b0, v_fetch(1'b0), v_fetch(1'b0), "fetch_wait");
        step(1'b1, v_fetch(1'b1), v_fetch(1'b1), "fetch");
        step(1'($urandom_range(0, 1)), V_DECODE, V_DECODE, "decode");
        case (op)
            LW, SW: begin
                step(1'($urandom_range(0, 1)), V_MEMADR, V_MEMADR, "memadr");
                v = (op == LW) ? V_MEMREAD : V_MEMWRITE;
                for (int i = 0; i < mw; i++) step(1'b0, v, v, "mem_wait");
                step(1'b1, v, v, "mem_done");
                if (op == LW) step(1'($urandom_range(0, 1)), V_MEMWB, V_MEMWB, "memwb");
            end
            ADD: begin
                step(1'($urandom_range(0, 1)), V_EXECR, V_EXECR, "execr");
                step(1'($urandom_range(0, 1)), V_ALUWB, V_ALUWB, "aluwb");
            end
            ADDI: begin
                step(1'($urandom_range(0, 1)), V_EXECI, V_EXECI, "execi");
                step(1'($urandom_range(0, 1)), V_ALUWB, V_ALUWB, "aluwb");
            end
            BEQ: step(1'($urandom_range(0, 1)), V_BEQ, V_BEQ, "beq");
            JAL: begin
                step(1'($urandom_range(0, 1)), V_JAL, V_JAL, "jal");
                step(1'($urandom_range(0, 1)), V_ALUWB, V_ALUWB, "jal_aluwb");
            end
            default: ;
        endcase
        retire_one();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        run_instr(ADD, 0, 0);
        run_instr(LW, 0, 2);
        run_instr(SW, 0, 1);

        // Preload the counter of the NOP instance so three retirements roll it over.
        do_reset(1);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        force dut0.instret_q = 32'hFFFF_FFFD;
        #1;
        release dut0.instret_q;
        cnt0 = 32'hFFFF_FFFD;
`endif
        run_instr(JAL, 0, 0);
        run_instr(BEQ, 1, 0);
        run_instr(ADDI, 0, 0);
        chk("instret_three", instret1, INSTRET_ON ? 32'd3 : 32'd0);
        chk("instret_wrap", instret0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset in the middle of a stalled load aborts it with no strobe left high.
        opcode = LW;
        step(1'b1, v_fetch(1'b1), v_fetch(1'b1), "abort_fetch");
        step(1'b0, V_DECODE, V_DECODE, "abort_decode");
        step(1'b0, V_MEMADR, V_MEMADR, "abort_memadr");
        step(1'b0, V_MEMREAD, V_MEMREAD, "abort_memread");
        do_reset(2);
        run_instr(ADD, 0, 0);

        // Illegal opcode: NOP instance loops FETCH/DECODE without retiring, trap instance sticks.
        opcode = SYS;
        step(1'b1, v_fetch(1'b1), v_fetch(1'b1), "illegal_fetch");
        step(1'b1, V_DECODE, V_DECODE, "illegal_decode");
        for (int k = 0; k < 10; k++) begin
            step(1'b1, (k % 2 == 0) ? v_fetch(1'b1) : V_DECODE, V_TRAP, "illegal_hold");
        end
        do_reset(1);
        step(1'b1, v_fetch(1'b1), v_fetch(1'b1), "trap_cleared");
        opcode = BEQ;
        step(1'b0, V_DECODE, V_DECODE, "post_trap_decode");
        step(1'b0, V_BEQ, V_BEQ, "post_trap_beq");
        retire_one();
        run_instr(ADDI, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
